// File: rtl/ex_div_seq.sv
// Execute-stage sequencer: runs a radix-2 restoring divider, stalls ID while it
// works, and shares the single register-file write port with the ALU result path.
module ex_div_seq #(
    parameter int WORD  = 32,
    parameter int W_RD  = 5,
    parameter int W_CNT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    input  logic              div_i,
    input  logic              signed_i,
    input  logic              rem_i,
    input  logic              halt_i,
    input  logic [WORD-1:0]   src_i,
    input  logic [WORD-1:0]   dest_i,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   wb_rd_name_i,
    input  logic [WORD-1:0]   alu_data_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              dz_o,
    output logic              wb_o,
    output logic [W_RD-1:0]   wb_rd_name_o,
    output logic [WORD-1:0]   wb_rd_data_o
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE, S_HALT} state_t;

    state_t            state_reg, state_next;
    logic [W_CNT-1:0]  cnt_reg;
    logic [WORD-1:0]   rem_reg, quo_reg, dvsr_reg, dvnd_reg;
    logic [W_RD-1:0]   cap_rd_reg;
    logic              cap_wb_reg, rem_sel_reg, q_neg_reg, r_neg_reg;

    logic              wb_reg, busy_reg, dz_reg;
    logic [W_RD-1:0]   wb_rd_name_reg;
    logic [WORD-1:0]   wb_rd_data_reg;

    logic              wb_next, busy_next, dz_next, stall_int, accept;
    logic [W_RD-1:0]   wb_rd_name_next;
    logic [WORD-1:0]   wb_rd_data_next;

    logic [WORD-1:0]   dest_mag, src_mag, rem_step, quo_step;
    logic [WORD-1:0]   q_fin, r_fin, result;
    logic [WORD:0]     partial, diff;
    logic              no_borrow, div_zero;

    assign accept   = (state_reg == S_IDLE) & v_i & div_i & ~halt_i;
    assign dest_mag = (signed_i & dest_i[WORD-1]) ? -dest_i : dest_i;
    assign src_mag  = (signed_i & src_i[WORD-1])  ? -src_i  : src_i;

    // One restoring step: shift the next dividend bit into the partial remainder
    // and keep the subtraction only when it does not borrow.
    assign partial   = {rem_reg, quo_reg[WORD-1]};
    assign diff      = partial - {1'b0, dvsr_reg};
    assign no_borrow = ~diff[WORD];
    assign rem_step  = no_borrow ? diff[WORD-1:0] : partial[WORD-1:0];
    assign quo_step  = {quo_reg[WORD-2:0], no_borrow};

    // The divide-by-zero result is fixed, so the iterated values are simply overridden.
    assign div_zero = (dvsr_reg == '0);
    assign q_fin    = q_neg_reg ? -quo_reg : quo_reg;
    assign r_fin    = r_neg_reg ? -rem_reg : rem_reg;
    assign result   = div_zero ? (rem_sel_reg ? dvnd_reg : '1)
                               : (rem_sel_reg ? r_fin : q_fin);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (v_i & halt_i)     state_next = S_HALT;
                else if (v_i & div_i) state_next = S_DIV;
            end
            S_DIV:   if (cnt_reg == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall_int       = 1'b0;
        wb_next         = 1'b0;
        wb_rd_name_next = wb_rd_name_reg;
        wb_rd_data_next = wb_rd_data_reg;
        dz_next         = dz_reg;
        case (state_reg)
            S_IDLE: begin
                stall_int = v_i & (halt_i | div_i);
                if (v_i & ~halt_i & ~div_i & wb_i) begin
                    wb_next         = 1'b1;
                    wb_rd_name_next = wb_rd_name_i;
                    wb_rd_data_next = alu_data_i;
                end
            end
            S_DIV: stall_int = 1'b1;
            S_DONE: begin
                dz_next = div_zero;
                if (cap_wb_reg) begin
                    wb_next         = 1'b1;
                    wb_rd_name_next = cap_rd_reg;
                    wb_rd_data_next = result;
                end
            end
            S_HALT:  stall_int = 1'b1;
            default: stall_int = 1'b0;
        endcase
    end

    assign busy_next = (state_next == S_DIV) | (state_next == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg        <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            dvsr_reg       <= '0;
            dvnd_reg       <= '0;
            cap_rd_reg     <= '0;
            cap_wb_reg     <= 1'b0;
            rem_sel_reg    <= 1'b0;
            q_neg_reg      <= 1'b0;
            r_neg_reg      <= 1'b0;
            wb_reg         <= 1'b0;
            wb_rd_name_reg <= '0;
            wb_rd_data_reg <= '0;
            busy_reg       <= 1'b0;
            dz_reg         <= 1'b0;
        end else begin
            wb_reg         <= wb_next;
            wb_rd_name_reg <= wb_rd_name_next;
            wb_rd_data_reg <= wb_rd_data_next;
            busy_reg       <= busy_next;
            dz_reg         <= dz_next;
            if (accept) begin
                cnt_reg     <= W_CNT'(WORD - 1);
                rem_reg     <= '0;
                quo_reg     <= dest_mag;
                dvsr_reg    <= src_mag;
                dvnd_reg    <= dest_i;
                cap_rd_reg  <= wb_rd_name_i;
                cap_wb_reg  <= wb_i;
                rem_sel_reg <= rem_i;
                q_neg_reg   <= signed_i & (dest_i[WORD-1] ^ src_i[WORD-1]);
                r_neg_reg   <= signed_i & dest_i[WORD-1];
            end else if (state_reg == S_DIV) begin
                rem_reg <= rem_step;
                quo_reg <= quo_step;
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    // ID must also see no stall while the stage is held in reset.
    assign stall_o      = rst & stall_int;
    assign busy_o       = busy_reg;
    assign dz_o         = dz_reg;
    assign wb_o         = wb_reg;
    assign wb_rd_name_o = wb_rd_name_reg;
    assign wb_rd_data_o = wb_rd_data_reg;

endmodule

// File: tb/tb_ex_div_seq.sv
// Randomized self-checking bench for ex_div_seq against an arithmetic reference.
module tb_ex_div_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          v_i = 1'b0, div_i = 1'b0, signed_i = 1'b0, rem_i = 1'b0, halt_i = 1'b0, wb_i = 1'b0;
    logic [W-1:0]  src_i = '0, dest_i = '0, alu_data_i = '0;
    logic [4:0]    wb_rd_name_i = '0;
    logic          stall_o, busy_o, dz_o, wb_o;
    logic [4:0]    wb_rd_name_o;
    logic [W-1:0]  wb_rd_data_o;

    int checks = 0;
    int errors = 0;
    logic exp_dz = 1'b0;

    ex_div_seq #(.WORD(W), .W_RD(5), .W_CNT(6)) dut (
        .clk(clk), .rst(rst), .v_i(v_i), .div_i(div_i), .signed_i(signed_i),
        .rem_i(rem_i), .halt_i(halt_i), .src_i(src_i), .dest_i(dest_i),
        .wb_i(wb_i), .wb_rd_name_i(wb_rd_name_i), .alu_data_i(alu_data_i),
        .stall_o(stall_o), .busy_o(busy_o), .dz_o(dz_o), .wb_o(wb_o),
        .wb_rd_name_o(wb_rd_name_o), .wb_rd_data_o(wb_rd_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sg, input logic rm);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == '0) return rm ? a : '1;
        if (!sg) return rm ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? '0 : a;
        return rm ? W'(sa % sb) : W'(sa / sb);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        v_i = 1'b0; div_i = 1'b0; halt_i = 1'b0; wb_i = 1'b0;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [W-1:0] data, input logic wbf);
        v_i = 1'b1; div_i = 1'b0; halt_i = 1'b0; wb_i = wbf;
        wb_rd_name_i = rd; alu_data_i = data;
        #1;
        chk("alu_stall", W'(stall_o), 0);
        step();
        chk("alu_wb", W'(wb_o), W'(wbf));
        if (wbf) begin
            chk("alu_rd", W'(wb_rd_name_o), W'(rd));
            chk("alu_data", wb_rd_data_o, data);
        end
        chk("alu_dz", W'(dz_o), W'(exp_dz));
        $display("alu rd=%0d data=0x%0h wb=%0d", rd, data, wbf);
        drive_idle();
    endtask

    task automatic idle_cycle();
        drive_idle();
        step();
        chk("idle_wb", W'(wb_o), 0);
    endtask

    task automatic div_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                          input logic rm, input logic [4:0] rd, input logic wbf);
        int n;
        int bad_wb;
        logic [W-1:0] exp_res;
        exp_res = ref_div(a, b, sg, rm);
        v_i = 1'b1; div_i = 1'b1; halt_i = 1'b0; signed_i = sg; rem_i = rm;
        dest_i = a; src_i = b; wb_i = wbf; wb_rd_name_i = rd; alu_data_i = $urandom;
        #1;
        n = 0;
        bad_wb = 0;
        while (stall_o === 1'b1 && n < 200) begin
            if (n > 0 && wb_o !== 1'b0) bad_wb++;
            n++;
            step();
        end
        chk("div_stall_cycles", W'(n), W'(W + 1));
        chk("div_wb_during", W'(bad_wb), 0);
        chk("done_busy", W'(busy_o), 1);
        chk("done_wb", W'(wb_o), 0);
        step();
        exp_dz = (b == '0);
        chk("div_wb", W'(wb_o), W'(wbf));
        if (wbf) begin
            chk("div_rd", W'(wb_rd_name_o), W'(rd));
            chk("div_data", wb_rd_data_o, exp_res);
        end
        chk("div_dz", W'(dz_o), W'(exp_dz));
        chk("div_busy_after", W'(busy_o), 0);
        $display("div a=0x%0h b=0x%0h sg=%0d rm=%0d rd=%0d -> 0x%0h dz=%0d", a, b, sg, rm, rd, exp_res, exp_dz);
        drive_idle();
    endtask

    initial begin
        int bad;
        logic [W-1:0] a, b;
        logic sg;

        // Reset held while ID presents a divide: everything must read zero.
        v_i = 1'b1; div_i = 1'b1; wb_i = 1'b1; wb_rd_name_i = 5'd9; alu_data_i = 32'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb", W'(wb_o), 0);
        chk("rst_rd", W'(wb_rd_name_o), 0);
        chk("rst_data", wb_rd_data_o, 0);
        chk("rst_busy", W'(busy_o), 0);
        chk("rst_dz", W'(dz_o), 0);
        chk("rst_stall", W'(stall_o), 0);
        drive_idle();
        rst = 1'b1;
        step();

        alu_op(5'd3, 32'h1234, 1'b1);
        idle_cycle();

        div_op(32'd100, 32'd7, 1'b0, 1'b0, 5'd5, 1'b1);
        div_op(32'd100, 32'd7, 1'b0, 1'b1, 5'd5, 1'b1);
        div_op(-32'sd100, 32'd7, 1'b1, 1'b0, 5'd6, 1'b1);
        div_op(-32'sd100, 32'd7, 1'b1, 1'b1, 5'd6, 1'b1);
        div_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd7, 1'b1);
        div_op(32'd42, 32'd0, 1'b0, 1'b0, 5'd8, 1'b1);
        div_op(32'd42, 32'd0, 1'b1, 1'b1, 5'd8, 1'b1);
        // Back-to-back: ALU op enters the cycle the divide retires.
        div_op(32'd1000, 32'd3, 1'b0, 1'b0, 5'd10, 1'b1);
        alu_op(5'd11, 32'hCAFE_F00D, 1'b1);
        idle_cycle();

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                alu_op(5'($urandom), $urandom, 1'($urandom));
            end else begin
                sg = 1'($urandom);
                a = $urandom;
                case ($urandom_range(0, 7))
                    0:       b = '0;
                    1, 2, 3: b = $urandom_range(1, 20);
                    4:       b = $urandom & 32'hFF;
                    default: b = $urandom;
                endcase
                if (sg && $urandom_range(0, 1) == 1) b = -b;
                div_op(a, b, sg, 1'($urandom), 5'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        // Abort a divide partway through with an asynchronous reset.
        v_i = 1'b1; div_i = 1'b1; signed_i = 1'b0; rem_i = 1'b0;
        dest_i = 32'd500; src_i = 32'd9; wb_i = 1'b1; wb_rd_name_i = 5'd12;
        step();
        drive_idle();
        repeat (21) step();
        chk("mid_busy", W'(busy_o), 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_wb", W'(wb_o), 0);
        chk("abort_busy", W'(busy_o), 0);
        chk("abort_stall", W'(stall_o), 0);
        chk("abort_data", wb_rd_data_o, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_dz = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (wb_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        chk("abort_no_retire", W'(bad), 0);
        $display("reset abort of divide 500/9");

        alu_op(5'd13, 32'h0BAD_F00D, 1'b1);

        // HALT wins over div_i and then absorbs everything.
        v_i = 1'b1; halt_i = 1'b1; div_i = 1'b1; wb_i = 1'b1;
        #1;
        chk("halt_stall_in", W'(stall_o), 1);
        step();
        chk("halt_wb", W'(wb_o), 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            v_i = 1'($urandom); halt_i = 1'b0; div_i = 1'($urandom); wb_i = 1'b1;
            alu_data_i = $urandom;
            #1;
            if (stall_o !== 1'b1) bad++;
            step();
            if (wb_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        chk("halt_hold", W'(bad), 0);
        $display("halt absorbed 20 cycles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
Execute-stage sequencer for a shared multi-cycle resource: owns an iterative radix-2 divider, stalls ID while a division runs, and arbitrates the single register-file write port between the one-cycle ALU result path and the divider. Also latches HALT into a permanent stall. Sits between ID/ALU outputs and the register file.

Parameters:
WORD, 32, datapath width in bits (≥4)
W_RD, 5, register-name width
W_CNT, 6, iteration counter width; must satisfy 2^W_CNT > WORD

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
v_i  in  1  instruction valid from ID
div_i  in  1  instruction is a divide (dopc DIV bit)
signed_i  in  1  signed divide when 1, unsigned when 0
rem_i  in  1  return remainder when 1, quotient when 0
halt_i  in  1  instruction is HALT
src_i  in  WORD  divisor
dest_i  in  WORD  dividend
wb_i  in  1  instruction writes rd
wb_rd_name_i  in  W_RD  destination register
alu_data_i  in  WORD  one-cycle ALU result for the current instruction
stall_o  out  1  hold ID (combinational)
busy_o  out  1  divider active (registered)
dz_o  out  1  divide-by-zero flag of last completed divide (registered)
wb_o  out  1  register-file write enable (registered)
wb_rd_name_o  out  W_RD  write register name (registered)
wb_rd_data_o  out  WORD  write data (registered)

Behaviour:
- Reset (async, rst=0): state IDLE; wb_o=0, wb_rd_name_o=0, wb_rd_data_o=0, busy_o=0, dz_o=0, counter=0; stall_o=0. Reset mid-division aborts it with no writeback.
- States: IDLE, DIV, DONE, HALT.
- IDLE, v_i=1, halt_i=1 → HALT; no writeback. Halt takes priority over div_i.
- IDLE, v_i=1, div_i=1 → capture operands, rd name, wb_i, signed_i, rem_i; counter←WORD-1; → DIV; no writeback this edge.
- IDLE, otherwise → wb_o←v_i&wb_i, wb_rd_name_o←wb_rd_name_i, wb_rd_data_o←alu_data_i.
- DIV: one restoring step per cycle on magnitudes (MSB first); counter decrements; at counter=0 → DONE. Exactly WORD cycles in DIV.
- DONE: inputs ignored (ID still presents the divide); at edge → IDLE, wb_o←captured wb, wb_rd_name_o←captured rd, wb_rd_data_o←selected result, dz_o updated.
- HALT: absorbing until reset; wb_o←0.
- wb_o is a one-cycle pulse per retiring instruction; wb_rd_* hold their last value when wb_o=0.
- stall_o = (state==DIV) | (state==HALT) | (state==IDLE & v_i & div_i & ~halt_i) | (state==IDLE & v_i & halt_i). Low in DONE so ID advances on the DONE edge.
- busy_o=1 in DIV and DONE.
- Latency: divide accepted at edge E → wb_o=1 during cycle after edge E+WORD+1; stall_o high WORD+1 cycles.
- Signed: operate on |dest|,|src| (WORD-bit unsigned); quotient negated if signs differ; remainder takes sign of dividend. MIN/-1 → quotient MIN, remainder 0 (no trap).
- Divide by zero (src=0, either sign mode): full latency kept; quotient all-ones, remainder=dividend; dz_o←1. Otherwise dz_o←0 on retire.

Test Plan:
- Reset: hold rst=0 mid-stream → all outputs 0, stall_o=0; release, ALU op v_i=1,wb_i=1,rd=3,alu_data=0x1234 → next cycle wb_o=1, rd=3, data 0x1234.
- Unsigned div 100/7 rem_i=0, rd=5 → stall_o high 33 cycles, wb_o pulse with 14 at edge E+33; rem_i=1 → 2.
- Signed -100/7 → quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); 0x80000000/-1 signed → 0x80000000, dz_o=0.
- Divide by zero 42/0 → quotient 0xFFFFFFFF, remainder 42, dz_o=1, same latency.
- Back-to-back: divide then ALU op presented on DONE edge → divide retires one cycle, ALU op retires next cycle, no lost/duplicate wb_o.
- HALT after ALU op → stall_o stays 1 indefinitely, no further wb_o; assert rst=0 during a divide at count 10 → IDLE, no writeback.
